// File: rtl/nubus_mem_arbiter_if.sv
// Bundle of the NuBus-side, local-side and memory-side buses around the card memory arbiter.
// slave = arbiter view, master = requesters/memory view.
interface nubus_mem_arbiter_if;
    logic        nub_valid;
    logic [31:0] nub_addr;
    logic [31:0] nub_wdata;
    logic [3:0]  nub_wstrb;
    logic        nub_ready;
    logic [31:0] nub_rdata;

    logic        loc_valid;
    logic [31:0] loc_addr;
    logic [31:0] loc_wdata;
    logic [3:0]  loc_wstrb;
    logic        loc_lock;
    logic        loc_ready;
    logic [31:0] loc_rdata;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [1:0]  arb_owner;
    logic        arb_err;

    modport slave (
        input  nub_valid, nub_addr, nub_wdata, nub_wstrb,
        output nub_ready, nub_rdata,
        input  loc_valid, loc_addr, loc_wdata, loc_wstrb, loc_lock,
        output loc_ready, loc_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output arb_owner, arb_err
    );

    modport master (
        output nub_valid, nub_addr, nub_wdata, nub_wstrb,
        input  nub_ready, nub_rdata,
        output loc_valid, loc_addr, loc_wdata, loc_wstrb, loc_lock,
        input  loc_ready, loc_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  arb_owner, arb_err
    );
endinterface

// File: rtl/nubus_mem_arbiter.sv
// Two-way arbiter for the card memory port: NuBus has priority, the local CPU gets a starvation
// limit and a locked sequence. Define MEM_TIMEOUT_EN to build in the hung-cycle watchdog.
module nubus_mem_arbiter #(
    parameter int unsigned NUB_BURST      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               nub_clk,
    input  logic               nub_reset,
    nubus_mem_arbiter_if.slave bus
);
    // Encoding doubles as the arb_owner value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        NUB  = 2'b01,
        LOC  = 2'b10
    } state_e;

    localparam logic [3:0] BURST = 4'(NUB_BURST);

    state_e     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       lock_q, lock_d;
    logic       loc_idle_q, loc_idle_d;
    logic       timeout;
    logic       done;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE)
            wdog_d = '0;
        else if (!bus.mem_ready)
            wdog_d = wdog_q + 8'd1;
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) wdog_q <= '0;
        else           wdog_q <= wdog_d;
    end

    // Fires on the TIMEOUT_CYCLES-th granted cycle; a real mem_ready always wins.
    assign timeout = (state_q != IDLE) && !bus.mem_ready && (wdog_q == WDOG_LAST);
`else
    wire unused_timeout_cfg = |8'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    assign done = bus.mem_ready || timeout;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            lock_q     <= 1'b0;
            loc_idle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            lock_q     <= lock_d;
            loc_idle_q <= loc_idle_d;
        end
    end

    // NOTE: every comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        lock_d     = lock_q;
        loc_idle_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lock_q && bus.loc_valid) begin
                    state_d  = LOC;
                    streak_d = '0;
                end else if (bus.nub_valid && !lock_q &&
                             !(bus.loc_valid && streak_q == BURST)) begin
                    state_d = NUB;
                    if (bus.loc_valid && streak_q != BURST)
                        streak_d = streak_q + 4'd1;
                end else if (bus.loc_valid) begin
                    state_d  = LOC;
                    streak_d = '0;
                end else begin
                    streak_d = '0;
                end
                // Lock ends when the CPU releases it or stays silent for two idle cycles.
                if (lock_q && (!bus.loc_lock || (!bus.loc_valid && loc_idle_q)))
                    lock_d = 1'b0;
                loc_idle_d = !bus.loc_valid;
            end
            NUB: begin
                if (done) state_d = IDLE;
            end
            LOC: begin
                if (done) begin
                    state_d = IDLE;
                    if (bus.loc_lock) lock_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.nub_ready = 1'b0;
        bus.nub_rdata = '0;
        bus.loc_ready = 1'b0;
        bus.loc_rdata = '0;
        bus.arb_owner = state_q;
        bus.arb_err   = timeout;
        unique case (state_q)
            NUB: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = bus.nub_addr;
                bus.mem_wdata = bus.nub_wdata;
                bus.mem_wstrb = bus.nub_wstrb;
                bus.nub_ready = done;
                bus.nub_rdata = timeout ? 32'hFFFF_FFFF : bus.mem_rdata;
            end
            LOC: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = bus.loc_addr;
                bus.mem_wdata = bus.loc_wdata;
                bus.mem_wstrb = bus.loc_wstrb;
                bus.loc_ready = done;
                bus.loc_rdata = timeout ? 32'hFFFF_FFFF : bus.mem_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Directed bench for nubus_mem_arbiter: reset, single read, contention, lock and watchdog.
module tb_nubus_mem_arbiter;
    logic nub_clk = 1'b0;
    logic nub_reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    nubus_mem_arbiter_if bus();

    nubus_mem_arbiter #(
        .NUB_BURST      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .nub_clk   (nub_clk),
        .nub_reset (nub_reset),
        .bus       (bus)
    );

    always #5 nub_clk = ~nub_clk;

    // Owner per cycle with both sides requesting and memory always ready.
    logic [1:0] cont_exp [12] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1,
                                  2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    // Owner per cycle for the locked three-write sequence with NuBus waiting.
    logic [1:0] lock_exp [9]  = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2,
                                  2'd0, 2'd0, 2'd1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge nub_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge nub_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_time_limit: observed no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        int bad;
        nub_reset     = 1'b1;
        bus.nub_valid = 1'b0;
        bus.nub_addr  = '0;
        bus.nub_wdata = '0;
        bus.nub_wstrb = '0;
        bus.loc_valid = 1'b0;
        bus.loc_addr  = '0;
        bus.loc_wdata = '0;
        bus.loc_wstrb = '0;
        bus.loc_lock  = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        tick();
        tick();
        settle();
        check("rst_mem_valid", 32'(bus.mem_valid), 0);
        check("rst_owner", 32'(bus.arb_owner), 0);
        check("rst_nub_ready", 32'(bus.nub_ready), 0);
        check("rst_arb_err", 32'(bus.arb_err), 0);
        tick();
        nub_reset = 1'b0;

        // Single NuBus read, memory answers on the second granted cycle
        bus.nub_valid = 1'b1;
        bus.nub_addr  = 32'hF300_0010;
        settle();
        check("rd_latency_mem_valid", 32'(bus.mem_valid), 0);
        tick();
        settle();
        check("rd_owner", 32'(bus.arb_owner), 1);
        check("rd_mem_addr", bus.mem_addr, 32'hF300_0010);
        check("rd_wait_nub_ready", 32'(bus.nub_ready), 0);
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("rd_nub_ready", 32'(bus.nub_ready), 1);
        check("rd_nub_rdata", bus.nub_rdata, 32'hDEAD_BEEF);
        check("rd_loc_ready", 32'(bus.loc_ready), 0);
        check("rd_loc_rdata", bus.loc_rdata, 0);
        tick();
        bus.nub_valid = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check("rd_bubble_owner", 32'(bus.arb_owner), 0);
        check("rd_bubble_nub_ready", 32'(bus.nub_ready), 0);

        // Reset asserted in the middle of a NuBus cycle
        tick();
        bus.nub_valid = 1'b1;
        bus.nub_addr  = 32'hF300_0020;
        tick();
        settle();
        check("mid_owner", 32'(bus.arb_owner), 1);
        #2;
        nub_reset     = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("mid_rst_owner", 32'(bus.arb_owner), 0);
        check("mid_rst_mem_valid", 32'(bus.mem_valid), 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        check("mid_rst_nub_ready", 32'(bus.nub_ready), 0);
        tick();
        nub_reset     = 1'b0;
        bus.mem_ready = 1'b0;
        settle();
        check("rel_wait_owner", 32'(bus.arb_owner), 0);
        tick();
        settle();
        check("rel_grant_owner", 32'(bus.arb_owner), 1);
        bus.mem_ready = 1'b1;
        tick();
        bus.nub_valid = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Contention: four NuBus grants, then the local side, then NuBus again
        bus.nub_valid = 1'b1;
        bus.nub_addr  = 32'h0000_2000;
        bus.loc_valid = 1'b1;
        bus.loc_addr  = 32'h0000_1000;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            settle();
            check($sformatf("cont_owner_%0d", i), 32'(bus.arb_owner), 32'(cont_exp[i]));
            if (cont_exp[i] == 2'd2) begin
                check("cont_loc_ready", 32'(bus.loc_ready), 1);
                check("cont_loc_addr", bus.mem_addr, 32'h0000_1000);
                check("cont_nub_ready", 32'(bus.nub_ready), 0);
            end
            tick();
        end
        bus.nub_valid = 1'b0;
        bus.loc_valid = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Locked sequence of three local writes while NuBus waits
        bus.loc_valid = 1'b1;
        bus.loc_lock  = 1'b1;
        bus.loc_wstrb = 4'hF;
        bus.loc_addr  = 32'h0000_3000;
        bus.loc_wdata = 32'hA5A5_0000;
        bus.mem_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            settle();
            check($sformatf("lock_owner_%0d", i), 32'(bus.arb_owner), 32'(lock_exp[i]));
            if (lock_exp[i] == 2'd2) begin
                check("lock_wdata", bus.mem_wdata, 32'hA5A5_0000 + 32'(k));
                check("lock_wstrb", 32'(bus.mem_wstrb), 32'hF);
                k++;
            end
            tick();
            if (i == 0) begin
                bus.nub_valid = 1'b1;
                bus.nub_addr  = 32'h0000_4000;
            end
            if (i == 1 || i == 3) begin
                bus.loc_addr  = 32'h0000_3000 + 32'(4 * k);
                bus.loc_wdata = 32'hA5A5_0000 + 32'(k);
            end
            if (i == 5) begin
                bus.loc_valid = 1'b0;
                bus.loc_lock  = 1'b0;
            end
        end
        check("lock_write_count", 32'(k), 3);
        bus.nub_valid = 1'b0;
        bus.mem_ready = 1'b0;
        bus.loc_wstrb = 4'h0;
        tick();

        // Local read that memory never answers
        bus.loc_valid = 1'b1;
        bus.loc_addr  = 32'h0000_5000;
        settle();
        check("to_start_owner", 32'(bus.arb_owner), 0);
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int g = 1; g <= 8; g++) begin
            settle();
            check($sformatf("to_loc_ready_%0d", g), 32'(bus.loc_ready), (g == 8) ? 1 : 0);
            check($sformatf("to_arb_err_%0d", g), 32'(bus.arb_err), (g == 8) ? 1 : 0);
            if (g == 8) check("to_loc_rdata", bus.loc_rdata, 32'hFFFF_FFFF);
            tick();
        end
        bus.loc_valid = 1'b0;
        settle();
        check("to_after_owner", 32'(bus.arb_owner), 0);
        check("to_after_err", 32'(bus.arb_err), 0);
`else
        bad = 0;
        for (int g = 0; g < 300; g++) begin
            settle();
            if (bus.arb_owner != 2'd2 || bus.arb_err || bus.loc_ready) bad++;
            tick();
        end
        check("noto_bad_cycles", 32'(bad), 0);
        settle();
        check("noto_owner", 32'(bus.arb_owner), 2);
        bus.mem_ready = 1'b1;
        tick();
        bus.loc_valid = 1'b0;
        bus.mem_ready = 1'b0;
        settle();
        check("noto_after_owner", 32'(bus.arb_owner), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
